// File: rtl/memory_unit_gen2.sv
// Cell-memory front end: dual-read/single-write RAM, bump allocator with GC retry.
// Optional MEMORY_UNIT_BOUNDS_CHECK_EN flags out-of-range GET/SET addresses.
module memory_unit_gen2 #(
    parameter int unsigned ADDR_W        = 11,
    parameter int unsigned DATA_W        = 64,
    parameter int unsigned MEM_DEPTH     = 2048,
    parameter int unsigned HEAP_LIMIT    = 2047,
    parameter int unsigned FREE_PTR_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power,
    input  logic [1:0]        func,
    input  logic              execute,
    input  logic [ADDR_W-1:0] address1,
    input  logic [ADDR_W-1:0] address2,
    input  logic [DATA_W-1:0] write_data,
    input  logic              gc_done,
    input  logic [ADDR_W-1:0] gc_free_ptr,
    output logic [ADDR_W-1:0] free_addr,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              gc_req,
    output logic              err,
    output logic              is_ready
);
    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned SUM_W = ADDR_W + 1;
    localparam logic [IDX_W-1:0] INIT_IDX = IDX_W'(FREE_PTR_ADDR % MEM_DEPTH);
    localparam logic [1:0] F_GET = 2'd0, F_SET = 2'd1, F_ALLOC = 2'd2, F_SETFREE = 2'd3;

    typedef enum logic [3:0] {
        INIT_RD, INIT_WAIT, INIT_LOAD, IDLE, READ_WAIT, READ_DONE,
        WRITE_DONE, ALLOC_DONE, GC_WAIT, ALLOC_RETRY
    } state_e;

    state_e            state_q, state_d;
    logic              is_ready_q, is_ready_d, err_q, err_d, gc_req_q, gc_req_d;
    logic [ADDR_W-1:0] free_ptr_q, free_ptr_d, free_addr_q, free_addr_d;
    logic [DATA_W-1:0] read_data1_q, read_data1_d, read_data2_q, read_data2_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              oob1_q, oob1_d, oob2_q, oob2_d;
    logic              gc_pend_q, gc_pend_d;
    logic [ADDR_W-1:0] gc_ptr_q, gc_ptr_d;

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] ram_rd1, ram_rd2;
    logic              wren_c, rden_c, oob1_c, oob2_c, fits_c;
    logic [IDX_W-1:0]  idx1_c, idx2_c, rd_idx1_c;
    logic [ADDR_W-1:0] n_c;
    logic [SUM_W-1:0]  sum_c;

`ifdef MEMORY_UNIT_BOUNDS_CHECK_EN
    assign oob1_c = (32'(address1) >= MEM_DEPTH);
    assign oob2_c = (32'(address2) >= MEM_DEPTH);
`else
    assign oob1_c = 1'b0;
    assign oob2_c = 1'b0;
`endif

    assign idx1_c    = IDX_W'(32'(addr1_q) % MEM_DEPTH);
    assign idx2_c    = IDX_W'(32'(addr2_q) % MEM_DEPTH);
    assign rd_idx1_c = (state_q == INIT_RD) ? INIT_IDX : idx1_c;
    assign wren_c    = power && (state_q == WRITE_DONE) && !oob1_q;
    assign rden_c    = power && ((state_q == INIT_RD) || (state_q == READ_WAIT));

    // Length comes from the bus on first attempt, from the latched copy on retry.
    assign n_c    = (state_q == IDLE) ? write_data[ADDR_W-1:0] : wdata_q[ADDR_W-1:0];
    assign sum_c  = {1'b0, free_ptr_q} + {1'b0, n_c};
    assign fits_c = (32'(sum_c) <= HEAP_LIMIT);

    // Synchronous RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (wren_c) mem[idx1_c] <= wdata_q;
        if (rden_c) begin
            ram_rd1 <= mem[rd_idx1_c];
            ram_rd2 <= mem[idx2_c];
        end
    end

    always_comb begin
        state_d      = state_q;
        is_ready_d   = is_ready_q;
        err_d        = err_q;
        gc_req_d     = gc_req_q;
        free_ptr_d   = free_ptr_q;
        free_addr_d  = free_addr_q;
        read_data1_d = read_data1_q;
        read_data2_d = read_data2_q;
        addr1_d      = addr1_q;
        addr2_d      = addr2_q;
        wdata_d      = wdata_q;
        oob1_d       = oob1_q;
        oob2_d       = oob2_q;
        gc_pend_d    = gc_pend_q;
        gc_ptr_d     = gc_ptr_q;

        // gc_done is captured even while power is low.
        if (state_q == GC_WAIT && gc_done) begin
            gc_pend_d = 1'b1;
            gc_ptr_d  = gc_free_ptr;
        end

        if (power) begin
            case (state_q)
                INIT_RD:   state_d = INIT_WAIT;
                INIT_WAIT: state_d = INIT_LOAD;
                INIT_LOAD: begin
                    free_ptr_d = ram_rd1[ADDR_W-1:0];
                    is_ready_d = 1'b1;
                    state_d    = IDLE;
                end
                IDLE: begin
                    if (!is_ready_q) begin
                        is_ready_d = 1'b1;
                    end else if (execute) begin
                        is_ready_d = 1'b0;
                        err_d      = 1'b0;
                        addr1_d    = address1;
                        addr2_d    = address2;
                        wdata_d    = write_data;
                        case (func)
                            F_GET: begin
                                oob1_d  = oob1_c;
                                oob2_d  = oob2_c;
                                err_d   = oob1_c || oob2_c;
                                state_d = READ_WAIT;
                            end
                            F_SET: begin
                                oob1_d  = oob1_c;
                                err_d   = oob1_c;
                                state_d = WRITE_DONE;
                            end
                            F_ALLOC: begin
                                if (fits_c) begin
                                    free_addr_d = free_ptr_q;
                                    free_ptr_d  = sum_c[ADDR_W-1:0];
                                    state_d     = ALLOC_DONE;
                                end else begin
                                    gc_req_d = 1'b1;
                                    state_d  = GC_WAIT;
                                end
                            end
                            default: begin
                                free_ptr_d = write_data[ADDR_W-1:0];
                                state_d    = ALLOC_DONE;
                            end
                        endcase
                    end
                end
                READ_WAIT: state_d = READ_DONE;
                READ_DONE: begin
                    read_data1_d = oob1_q ? '0 : ram_rd1;
                    read_data2_d = oob2_q ? '0 : ram_rd2;
                    state_d      = IDLE;
                end
                WRITE_DONE: state_d = IDLE;
                ALLOC_DONE: state_d = IDLE;
                GC_WAIT: begin
                    if (gc_done || gc_pend_q) begin
                        gc_req_d   = 1'b0;
                        free_ptr_d = gc_done ? gc_free_ptr : gc_ptr_q;
                        gc_pend_d  = 1'b0;
                        state_d    = ALLOC_RETRY;
                    end
                end
                ALLOC_RETRY: begin
                    if (fits_c) begin
                        free_addr_d = free_ptr_q;
                        free_ptr_d  = sum_c[ADDR_W-1:0];
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ALLOC_DONE;
                end
                default: state_d = INIT_RD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= INIT_RD;
            is_ready_q   <= 1'b0;
            err_q        <= 1'b0;
            gc_req_q     <= 1'b0;
            free_ptr_q   <= '0;
            free_addr_q  <= '0;
            read_data1_q <= '0;
            read_data2_q <= '0;
            addr1_q      <= '0;
            addr2_q      <= '0;
            wdata_q      <= '0;
            oob1_q       <= 1'b0;
            oob2_q       <= 1'b0;
            gc_pend_q    <= 1'b0;
            gc_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            is_ready_q   <= is_ready_d;
            err_q        <= err_d;
            gc_req_q     <= gc_req_d;
            free_ptr_q   <= free_ptr_d;
            free_addr_q  <= free_addr_d;
            read_data1_q <= read_data1_d;
            read_data2_q <= read_data2_d;
            addr1_q      <= addr1_d;
            addr2_q      <= addr2_d;
            wdata_q      <= wdata_d;
            oob1_q       <= oob1_d;
            oob2_q       <= oob2_d;
            gc_pend_q    <= gc_pend_d;
            gc_ptr_q     <= gc_ptr_d;
        end
    end

    assign free_addr  = free_addr_q;
    assign read_data1 = read_data1_q;
    assign read_data2 = read_data2_q;
    assign gc_req     = gc_req_q;
    assign err        = err_q;
    assign is_ready   = is_ready_q & ~execute;
endmodule

// File: tb/tb_memory_unit_gen2.sv
// Directed bench for memory_unit_gen2 (instantiated with MEM_DEPTH=1024).
module tb_memory_unit_gen2;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst, power, execute, gc_done;
    logic [1:0]        func;
    logic [ADDR_W-1:0] address1, address2, gc_free_ptr;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] free_addr;
    logic [DATA_W-1:0] read_data1, read_data2;
    logic              gc_req, err, is_ready;

    int n_checks = 0;
    int n_err    = 0;
    int gc_rises = 0;
    logic gc_prev = 1'b0;

    memory_unit_gen2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(1024),
                       .HEAP_LIMIT(2047), .FREE_PTR_ADDR(0)) dut (
        .clk(clk), .rst(rst), .power(power), .func(func), .execute(execute),
        .address1(address1), .address2(address2), .write_data(write_data),
        .gc_done(gc_done), .gc_free_ptr(gc_free_ptr), .free_addr(free_addr),
        .read_data1(read_data1), .read_data2(read_data2), .gc_req(gc_req),
        .err(err), .is_ready(is_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (gc_req && !gc_prev) gc_rises++;
        gc_prev = gc_req;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (!is_ready && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!is_ready) chk("ready_timeout", 64'(is_ready), 64'd1);
    endtask

    task automatic issue(input logic [1:0] f, input logic [ADDR_W-1:0] a1,
                         input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] wd);
        int d;
        wait_ready(d);
        func = f; address1 = a1; address2 = a2; write_data = wd;
        execute = 1'b1;
        @(posedge clk); #1;
        execute = 1'b0;
    endtask

    task automatic cmd(input logic [1:0] f, input logic [ADDR_W-1:0] a1,
                       input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] wd, output int lat);
        issue(f, a1, a2, wd);
        wait_ready(lat);
    endtask

    task automatic gc_pulse(input logic [ADDR_W-1:0] p);
        gc_done = 1'b1; gc_free_ptr = p;
        @(posedge clk); #1;
        gc_done = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int lat, r0;
        rst = 1'b1; power = 1'b1; execute = 1'b0; gc_done = 1'b0; func = 2'd0;
        address1 = '0; address2 = '0; write_data = '0; gc_free_ptr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_free_addr", 64'(free_addr), 64'd0);
        chk("rst_rd1", read_data1, 64'd0);
        chk("rst_rd2", read_data2, 64'd0);
        chk("rst_gc_req", 64'(gc_req), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_ready", 64'(is_ready), 64'd0);
        rst = 1'b0;
        wait_ready(lat);

        // Seed boot free pointer, then reboot so init loads it.
        cmd(2'd1, 11'h000, 11'h000, 64'h0C8, lat);
        pulse_reset();
        wait_ready(lat);
        cmd(2'd2, 11'h0, 11'h0, 64'd2, lat);
        chk("alloc1_addr", 64'(free_addr), 64'h0C8);
        chk("alloc_lat", 64'(lat), 64'd2);
        cmd(2'd2, 11'h0, 11'h0, 64'd3, lat);
        chk("alloc2_addr", 64'(free_addr), 64'h0CA);
        cmd(2'd2, 11'h0, 11'h0, 64'd0, lat);
        chk("alloc_n0_a", 64'(free_addr), 64'h0CD);
        cmd(2'd2, 11'h0, 11'h0, 64'd0, lat);
        chk("alloc_n0_b", 64'(free_addr), 64'h0CD);

        cmd(2'd1, 11'h010, 11'h0, 64'hDEAD_BEEF, lat);
        chk("write_lat", 64'(lat), 64'd2);
        cmd(2'd1, 11'h011, 11'h0, 64'h1234_5678_9ABC_DEF0, lat);
        cmd(2'd0, 11'h010, 11'h011, 64'h0, lat);
        chk("read_lat", 64'(lat), 64'd3);
        chk("read_rd1", read_data1, 64'hDEAD_BEEF);
        chk("read_rd2", read_data2, 64'h1234_5678_9ABC_DEF0);

        // Allocation ending exactly at HEAP_LIMIT fits.
        cmd(2'd3, 11'h0, 11'h0, 64'd2040, lat);
        chk("setfree_lat", 64'(lat), 64'd2);
        cmd(2'd2, 11'h0, 11'h0, 64'd7, lat);
        chk("edge_alloc", 64'(free_addr), 64'd2040);
        chk("edge_gc", 64'(gc_req), 64'd0);
        cmd(2'd2, 11'h0, 11'h0, 64'd0, lat);
        chk("edge_ptr", 64'(free_addr), 64'd2047);

        // Overflow -> GC -> successful retry.
        cmd(2'd3, 11'h0, 11'h0, 64'd2040, lat);
        issue(2'd2, 11'h0, 11'h0, 64'd8);
        chk("gc_req_set", 64'(gc_req), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("gc_wait_ready", 64'(is_ready), 64'd0);
        chk("gc_wait_req", 64'(gc_req), 64'd1);
        gc_pulse(11'h100);
        chk("gc_req_clr", 64'(gc_req), 64'd0);
        wait_ready(lat);
        chk("gc_ok_addr", 64'(free_addr), 64'h100);
        chk("gc_ok_err", 64'(err), 64'd0);
        cmd(2'd2, 11'h0, 11'h0, 64'd0, lat);
        chk("gc_ok_ptr", 64'(free_addr), 64'h108);

        // Overflow -> GC -> retry still does not fit.
        cmd(2'd3, 11'h0, 11'h0, 64'd2040, lat);
        r0 = gc_rises;
        issue(2'd2, 11'h0, 11'h0, 64'd8);
        @(posedge clk); #1;
        gc_pulse(11'd2045);
        wait_ready(lat);
        chk("gc_fail_err", 64'(err), 64'd1);
        chk("gc_fail_addr", 64'(free_addr), 64'h108);
        chk("gc_fail_pulses", 64'(gc_rises - r0), 64'd1);
        chk("gc_fail_req", 64'(gc_req), 64'd0);
        cmd(2'd2, 11'h0, 11'h0, 64'd0, lat);
        chk("gc_fail_ptr", 64'(free_addr), 64'd2045);
        chk("err_cleared", 64'(err), 64'd0);

        // Reset in READ_WAIT.
        issue(2'd0, 11'h010, 11'h011, 64'h0);
        rst = 1'b1;
        #1;
        chk("midrst_rd1", read_data1, 64'd0);
        chk("midrst_addr", 64'(free_addr), 64'd0);
        chk("midrst_ready", 64'(is_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ready(lat);
        cmd(2'd2, 11'h0, 11'h0, 64'd0, lat);
        chk("reboot_ptr", 64'(free_addr), 64'h0C8);
        cmd(2'd0, 11'h010, 11'h011, 64'h0, lat);
        chk("reboot_rd1", read_data1, 64'hDEAD_BEEF);

        // Address beyond MEM_DEPTH.
        cmd(2'd1, 11'h100, 11'h0, 64'h55, lat);
        cmd(2'd1, 11'h500, 11'h0, 64'hABCD, lat);
`ifdef MEMORY_UNIT_BOUNDS_CHECK_EN
        chk("oob_set_err", 64'(err), 64'd1);
        cmd(2'd0, 11'h100, 11'h500, 64'h0, lat);
        chk("oob_rd1", read_data1, 64'h55);
        chk("oob_rd2", read_data2, 64'h0);
        chk("oob_get_err", 64'(err), 64'd1);
`else
        chk("wrap_set_err", 64'(err), 64'd0);
        cmd(2'd0, 11'h100, 11'h500, 64'h0, lat);
        chk("wrap_rd1", read_data1, 64'hABCD);
        chk("wrap_rd2", read_data2, 64'hABCD);
        chk("wrap_get_err", 64'(err), 64'd0);
`endif
        chk("oob_read_lat", 64'(lat), 64'd3);

        // gc_done outside GC_WAIT is ignored.
        gc_pulse(11'h033);
        cmd(2'd2, 11'h0, 11'h0, 64'd0, lat);
        chk("stray_gc_ptr", 64'(free_addr), 64'h0C8);

        // gc_done while powered down is latched and used later.
        cmd(2'd3, 11'h0, 11'h0, 64'd2040, lat);
        issue(2'd2, 11'h0, 11'h0, 64'd8);
        power = 1'b0;
        gc_pulse(11'h200);
        repeat (3) @(posedge clk);
        #1;
        chk("pwr_hold_req", 64'(gc_req), 64'd1);
        chk("pwr_hold_ready", 64'(is_ready), 64'd0);
        power = 1'b1;
        wait_ready(lat);
        chk("pwr_gc_addr", 64'(free_addr), 64'h200);
        chk("pwr_gc_req", 64'(gc_req), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
